bram_sdp: RTL

Parametrised simple-dual-port block RAM: one write port with per-column enables and one read port with a read enable. The read-during-write behaviour is selectable, an optional output pipeline register is available, and an optional post-reset clear sequencer zeroes every word before the RAM accepts traffic. It is the general-purpose storage primitive for register files, FIFOs and caches, and it maps onto FPGA block RAM.

---
 rtl/bram_pkg.sv | 20 ++
 rtl/bram_sdp_core.sv | 45 ++++
 rtl/bram_sdp.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/bram_pkg.sv
// Shared types and helpers for the simple-dual-port block RAM.
package bram_pkg;

  typedef enum logic [1:0] {
    RD_NO_CHANGE,
    RD_READ_FIRST,
    RD_WRITE_FIRST
  } rd_mode_t;

  typedef enum logic {
    StInit,
    StReady
  } seq_state_e;

  function automatic int unsigned col_width(input int unsigned data_width,
                                            input int unsigned num_col);
    return data_width / num_col;
  endfunction

endpackage

// File: rtl/bram_sdp_core.sv
// Flat storage array with per-column write and a registered read port, kept simple so
// synthesis maps it straight onto block RAM.
module bram_sdp_core
  import bram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_COL    = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_COL-1:0]    we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int unsigned ColW  = col_width(DATA_WIDTH, NUM_COL);
  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < int'(NUM_COL); i++) begin
      if (we_i[i]) begin
        mem_q[waddr_i][i*ColW +: ColW] <= wdata_i[i*ColW +: ColW];
      end
    end
  end

  // Output register uses the BRAM's synchronous output reset; the array itself is not reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bram_sdp.sv
// Simple-dual-port RAM wrapper: clear sequencer, read acceptance, read-during-write policy
// and optional output register around the flat storage core.
module bram_sdp
  import bram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned NUM_COL        = 1,
  parameter rd_mode_t    RD_MODE        = RD_NO_CHANGE,
  parameter bit          OUT_REG        = 1'b0,
  parameter bit          CLEAR_ON_RESET = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_COL-1:0]    wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  output logic                  init_busy_o
);

  localparam int unsigned ColW  = col_width(DATA_WIDTH, NUM_COL);
  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LastAddr = (ADDR_WIDTH + 1)'(Depth - 1);

  if (DATA_WIDTH % NUM_COL != 0) begin : g_bad_cols
    $error("DATA_WIDTH must be a multiple of NUM_COL");
  end

  seq_state_e            state_q;
  logic [ADDR_WIDTH:0]   cnt_q;
  logic                  in_init;
  logic                  acc;
  logic [NUM_COL-1:0]    core_we;
  logic [ADDR_WIDTH-1:0] core_waddr;
  logic [DATA_WIDTH-1:0] core_wdata;
  logic [DATA_WIDTH-1:0] core_rdata;
  logic [DATA_WIDTH-1:0] wf_mask_d, wf_mask_q, wf_data_q;
  logic                  valid1_q;
  logic [DATA_WIDTH-1:0] stage1_data;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= CLEAR_ON_RESET ? StInit : StReady;
      cnt_q   <= '0;
    end else if (state_q == StInit) begin
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == LastAddr) begin
        state_q <= StReady;
      end
    end
  end

  assign in_init     = (state_q == StInit);
  assign init_busy_o = in_init;

  // The clear sequencer owns the write port while INIT; reset blocks all writes.
  always_comb begin
    core_we    = '0;
    core_waddr = wr_addr_i;
    core_wdata = wr_data_i;
    if (!rst_i) begin
      if (in_init) begin
        core_we    = '1;
        core_waddr = cnt_q[ADDR_WIDTH-1:0];
        core_wdata = '0;
      end else begin
        core_we = wr_en_i;
      end
    end
  end

  assign acc = !rst_i && !in_init && rd_en_i && !(RD_MODE == RD_NO_CHANGE && |wr_en_i);

  always_comb begin
    wf_mask_d = '0;
    if (RD_MODE == RD_WRITE_FIRST && rd_addr_i == wr_addr_i) begin
      for (int i = 0; i < int'(NUM_COL); i++) begin
        wf_mask_d[i*ColW +: ColW] = {ColW{wr_en_i[i]}};
      end
    end
  end

  // Bypass capture advances only with an accepted read so stage 1 holds as a unit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid1_q  <= 1'b0;
      wf_mask_q <= '0;
      wf_data_q <= '0;
    end else begin
      valid1_q <= acc;
      if (acc) begin
        wf_mask_q <= wf_mask_d;
        wf_data_q <= wr_data_i;
      end
    end
  end

  bram_sdp_core #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_COL    (NUM_COL)
  ) u_core (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (core_we),
    .waddr_i (core_waddr),
    .wdata_i (core_wdata),
    .re_i    (acc),
    .raddr_i (rd_addr_i),
    .rdata_o (core_rdata)
  );

  assign stage1_data = (core_rdata & ~wf_mask_q) | (wf_data_q & wf_mask_q);

  if (OUT_REG) begin : g_out_reg
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= valid1_q;
        if (valid1_q) begin
          rd_data_q <= stage1_data;
        end
      end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
  end else begin : g_no_out_reg
    assign rd_data_o  = stage1_data;
    assign rd_valid_o = valid1_q;
  end

endmodule
